rs_issue_select: RTL and testbench

- Downstream neighbour of the reservation station block.
- Each cycle, scans the station entries and picks the oldest one whose two source operands are both ready. It tells the station to clear that entry and holds the chosen instruction in a one-deep output register until the functional unit accepts it.
- Age order is tracked internally with an age matrix that is updated on every station allocation.

---
 rtl/rs_issue_select_if.sv | 39 +++
 rtl/rs_issue_select.sv | 94 +++++++++
 tb/tb_rs_issue_select.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/rs_issue_select_if.sv
// rs_issue_select_if: station-facing and issue-facing bus of rs_issue_select
interface rs_issue_select_if #(
   parameter int STATION_IDX_WIDTH   = 2,
   parameter int REG_FILE_ADDR_WIDTH = 7,
   parameter int INSTR_WIDTH         = 32
);
   localparam int N = 2**STATION_IDX_WIDTH;
   logic                             alloc_en;
   logic [STATION_IDX_WIDTH-1:0]     alloc_idx;
   logic [N-1:0]                     entry_valid;
   logic [N-1:0]                     entry_rs1_ready;
   logic [N-1:0]                     entry_rs2_ready;
   logic [N*REG_FILE_ADDR_WIDTH-1:0] entry_rs1;
   logic [N*REG_FILE_ADDR_WIDTH-1:0] entry_rs2;
   logic [N*REG_FILE_ADDR_WIDTH-1:0] entry_rd;
   logic [N*INSTR_WIDTH-1:0]         entry_instr;
   logic                             cdb_valid;
   logic [REG_FILE_ADDR_WIDTH-1:0]   cdb_tag;
   logic                             flush;
   logic                             clear_en;
   logic [STATION_IDX_WIDTH-1:0]     clear_idx;
   logic                             issue_valid;
   logic                             issue_ready;
   logic [STATION_IDX_WIDTH-1:0]     issue_idx;
   logic [INSTR_WIDTH-1:0]           issue_instr;
   logic [REG_FILE_ADDR_WIDTH-1:0]   issue_rd;
   logic [REG_FILE_ADDR_WIDTH-1:0]   issue_rs1;
   logic [REG_FILE_ADDR_WIDTH-1:0]   issue_rs2;
   modport master (
      output alloc_en, alloc_idx, entry_valid, entry_rs1_ready, entry_rs2_ready,
             entry_rs1, entry_rs2, entry_rd, entry_instr, cdb_valid, cdb_tag, flush, issue_ready,
      input  clear_en, clear_idx, issue_valid, issue_idx, issue_instr, issue_rd, issue_rs1, issue_rs2
   );
   modport slave (
      input  alloc_en, alloc_idx, entry_valid, entry_rs1_ready, entry_rs2_ready,
             entry_rs1, entry_rs2, entry_rd, entry_instr, cdb_valid, cdb_tag, flush, issue_ready,
      output clear_en, clear_idx, issue_valid, issue_idx, issue_instr, issue_rd, issue_rs1, issue_rs2
   );
endinterface

// File: rtl/rs_issue_select.sv
// rs_issue_select: oldest-ready pick from the reservation station into a one-deep issue register (optional RS_ISSUE_CDB_BYPASS_EN)
module rs_issue_select #(
   parameter int STATION_IDX_WIDTH   = 2,
   parameter int REG_FILE_ADDR_WIDTH = 7,
   parameter int INSTR_WIDTH         = 32
) (
   input logic              clock,
   input logic              reset,
   rs_issue_select_if.slave bus
);
   localparam int N = 2**STATION_IDX_WIDTH;
   localparam int W = REG_FILE_ADDR_WIDTH;
   logic [N-1:0]                 r_older [N];
   logic [N-1:0]                 w_rs1_rdy;
   logic [N-1:0]                 w_rs2_rdy;
   logic [N-1:0]                 w_cand;
   logic [N-1:0]                 w_sel;
   logic [STATION_IDX_WIDTH-1:0] w_sel_idx;
   logic                         w_slot_free;
   logic                         w_fire;
   logic                         r_issue_valid;
   logic [STATION_IDX_WIDTH-1:0] r_issue_idx;
   logic [INSTR_WIDTH-1:0]       r_issue_instr;
   logic [W-1:0]                 r_issue_rd;
   logic [W-1:0]                 r_issue_rs1;
   logic [W-1:0]                 r_issue_rs2;
`ifdef RS_ISSUE_CDB_BYPASS_EN
   // operand readiness including a same-cycle CDB wakeup
   always_comb begin
      w_rs1_rdy = bus.entry_rs1_ready;
      w_rs2_rdy = bus.entry_rs2_ready;
      for (int i = 0; i < N; i++) begin
         w_rs1_rdy[i] = w_rs1_rdy[i] | (bus.cdb_valid & (bus.cdb_tag == bus.entry_rs1[i*W +: W]));
         w_rs2_rdy[i] = w_rs2_rdy[i] | (bus.cdb_valid & (bus.cdb_tag == bus.entry_rs2[i*W +: W]));
      end
   end
`else
   logic w_unused_cdb;
   assign w_unused_cdb = bus.cdb_valid ^ (^bus.cdb_tag);
   assign w_rs1_rdy    = bus.entry_rs1_ready;
   assign w_rs2_rdy    = bus.entry_rs2_ready;
`endif
   assign w_cand = bus.entry_valid & w_rs1_rdy & w_rs2_rdy;
   // age matrix: a newly allocated entry becomes younger than every other entry
   always_ff @(posedge clock or negedge reset)
      if (!reset)
         for (int i = 0; i < N; i++) r_older[i] <= '0;
      else if (bus.alloc_en)
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               if (i == int'(bus.alloc_idx)) r_older[i][j] <= 1'b0;
               else if (j == int'(bus.alloc_idx)) r_older[i][j] <= 1'b1;
   // a candidate is selected when no other candidate is older than it
   always_comb begin
      w_sel = w_cand;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            if (j != i && w_cand[j] && r_older[j][i]) w_sel[i] = 1'b0;
   end
   // lowest selected index wins if a corrupt matrix leaves several
   always_comb begin
      w_sel_idx = '0;
      for (int i = N-1; i >= 0; i--)
         if (w_sel[i]) w_sel_idx = STATION_IDX_WIDTH'(i);
   end
   assign w_slot_free   = !r_issue_valid | bus.issue_ready;
   assign w_fire        = reset & w_slot_free & (|w_sel) & !bus.flush;
   assign bus.clear_en  = w_fire;
   assign bus.clear_idx = w_sel_idx;
   // one-deep issue register: capture, hold, drain or flush
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         r_issue_valid <= 1'b0;
         r_issue_idx   <= '0;
         r_issue_instr <= '0;
         r_issue_rd    <= '0;
         r_issue_rs1   <= '0;
         r_issue_rs2   <= '0;
      end else if (w_fire) begin
         r_issue_valid <= 1'b1;
         r_issue_idx   <= w_sel_idx;
         r_issue_instr <= bus.entry_instr[w_sel_idx*INSTR_WIDTH +: INSTR_WIDTH];
         r_issue_rd    <= bus.entry_rd[w_sel_idx*W +: W];
         r_issue_rs1   <= bus.entry_rs1[w_sel_idx*W +: W];
         r_issue_rs2   <= bus.entry_rs2[w_sel_idx*W +: W];
      end else if (bus.flush | w_slot_free)
         r_issue_valid <= 1'b0;
   assign bus.issue_valid = r_issue_valid;
   assign bus.issue_idx   = r_issue_idx;
   assign bus.issue_instr = r_issue_instr;
   assign bus.issue_rd    = r_issue_rd;
   assign bus.issue_rs1   = r_issue_rs1;
   assign bus.issue_rs2   = r_issue_rs2;
endmodule

// File: tb/tb_rs_issue_select.sv
// tb_rs_issue_select: directed checks of oldest-ready selection, hold, flush, bypass and async reset
module tb_rs_issue_select;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;
   int   n_fail = 0;
   rs_issue_select_if #(.STATION_IDX_WIDTH(2), .REG_FILE_ADDR_WIDTH(7), .INSTR_WIDTH(32)) bus ();
   rs_issue_select #(.STATION_IDX_WIDTH(2), .REG_FILE_ADDR_WIDTH(7), .INSTR_WIDTH(32)) dut (
      .clock(clk),
      .reset(rst_n),
      .bus  (bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // one clock; the station drops the entry cleared at this edge
   task automatic tick();
      logic       c;
      logic [1:0] ci;
      c  = bus.clear_en;
      ci = bus.clear_idx;
      @(posedge clk);
      #1;
      if (c) bus.entry_valid[ci] = 1'b0;
      bus.alloc_en = 1'b0;
   endtask
   task automatic alloc(input int idx, input logic r1, input logic r2, input logic [6:0] rs1);
      bus.alloc_en  = 1'b1;
      bus.alloc_idx = idx[1:0];
      @(negedge clk);
      tick();
      bus.entry_valid[idx]        = 1'b1;
      bus.entry_rs1_ready[idx]    = r1;
      bus.entry_rs2_ready[idx]    = r2;
      bus.entry_rs1[idx*7 +: 7]   = rs1;
      bus.entry_rs2[idx*7 +: 7]   = 7'h30 + 7'(idx);
      bus.entry_rd[idx*7 +: 7]    = 7'h10 + 7'(idx);
      bus.entry_instr[idx*32 +: 32] = 32'hA000_0000 + 32'(idx);
   endtask
   initial begin
      bus.alloc_en = 0; bus.alloc_idx = 0; bus.entry_valid = 0;
      bus.entry_rs1_ready = 0; bus.entry_rs2_ready = 0;
      bus.entry_rs1 = 0; bus.entry_rs2 = 0; bus.entry_rd = 0; bus.entry_instr = 0;
      bus.cdb_valid = 0; bus.cdb_tag = 0; bus.flush = 0; bus.issue_ready = 1;
      repeat (2) @(negedge clk);
      chk("rst_valid", bus.issue_valid, 0);
      chk("rst_idx", bus.issue_idx, 0);
      chk("rst_instr", bus.issue_instr, 0);
      chk("rst_clear", bus.clear_en, 0);
      rst_n = 1'b1;
      // age order 2, 0, 1
      alloc(2, 0, 0, 7'h22);
      alloc(0, 0, 0, 7'h20);
      alloc(1, 0, 0, 7'h21);
      bus.entry_rs1_ready = 4'b0111;
      bus.entry_rs2_ready = 4'b0111;
      @(negedge clk);
      chk("ord_clear0", bus.clear_en, 1);
      chk("ord_cidx0", bus.clear_idx, 2);
      chk("ord_valid0", bus.issue_valid, 0);
      tick(); @(negedge clk);
      chk("ord_valid1", bus.issue_valid, 1);
      chk("ord_idx1", bus.issue_idx, 2);
      chk("ord_instr1", bus.issue_instr, 32'hA000_0002);
      chk("ord_cidx1", bus.clear_idx, 0);
      tick(); @(negedge clk);
      chk("ord_idx2", bus.issue_idx, 0);
      chk("ord_clear2", bus.clear_en, 1);
      chk("ord_cidx2", bus.clear_idx, 1);
      tick(); @(negedge clk);
      chk("ord_idx3", bus.issue_idx, 1);
      chk("ord_rd3", bus.issue_rd, 7'h11);
      chk("ord_clear3", bus.clear_en, 0);
      tick(); @(negedge clk);
      chk("drain_valid", bus.issue_valid, 0);
      // older entry blocked on rs2, younger ready entry goes first
      alloc(1, 1, 0, 7'h21);
      alloc(3, 1, 1, 7'h23);
      @(negedge clk);
      chk("blk_clear", bus.clear_en, 1);
      chk("blk_cidx", bus.clear_idx, 3);
      tick();
      bus.entry_rs2_ready[1] = 1'b1;
      @(negedge clk);
      chk("blk_idx3", bus.issue_idx, 3);
      chk("blk_rs1", bus.issue_rs1, 7'h23);
      chk("blk_cidx1", bus.clear_idx, 1);
      tick(); @(negedge clk);
      chk("blk_idx1", bus.issue_idx, 1);
      chk("blk_rs2", bus.issue_rs2, 7'h31);
      tick();
      // backpressure holds the first entry
      bus.issue_ready = 1'b0;
      alloc(0, 0, 1, 7'h20);
      alloc(2, 0, 1, 7'h22);
      bus.entry_rs1_ready[0] = 1'b1;
      bus.entry_rs1_ready[2] = 1'b1;
      @(negedge clk);
      chk("bp_clear", bus.clear_en, 1);
      chk("bp_cidx", bus.clear_idx, 0);
      tick();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("bp_hold_valid", bus.issue_valid, 1);
         chk("bp_hold_idx", bus.issue_idx, 0);
         chk("bp_hold_instr", bus.issue_instr, 32'hA000_0000);
         chk("bp_hold_clear", bus.clear_en, 0);
         tick();
      end
      bus.issue_ready = 1'b1;
      @(negedge clk);
      chk("bp_rel_clear", bus.clear_en, 1);
      chk("bp_rel_cidx", bus.clear_idx, 2);
      tick(); @(negedge clk);
      chk("bp_idx2", bus.issue_idx, 2);
      chk("bp_instr2", bus.issue_instr, 32'hA000_0002);
      tick(); @(negedge clk);
      chk("bp_drain", bus.issue_valid, 0);
      // flush kills the output and suppresses capture
      alloc(1, 0, 1, 7'h21);
      alloc(3, 0, 1, 7'h23);
      bus.entry_rs1_ready[1] = 1'b1;
      bus.entry_rs1_ready[3] = 1'b1;
      @(negedge clk);
      tick(); @(negedge clk);
      chk("fl_valid", bus.issue_valid, 1);
      chk("fl_idx", bus.issue_idx, 1);
      chk("fl_pre_clear", bus.clear_en, 1);
      bus.flush = 1'b1;
      #1;
      chk("fl_clear", bus.clear_en, 0);
      tick();
      chk("fl_valid_after", bus.issue_valid, 0);
      bus.flush = 1'b0;
      bus.entry_valid = 0;
      @(negedge clk);
      chk("fl_idle_clear", bus.clear_en, 0);
      // CDB wakeup of rs1
      alloc(0, 0, 1, 7'h15);
      bus.cdb_valid = 1'b1;
      bus.cdb_tag   = 7'h15;
      @(negedge clk);
`ifdef RS_ISSUE_CDB_BYPASS_EN
      chk("cdb_clear", bus.clear_en, 1);
      chk("cdb_cidx", bus.clear_idx, 0);
`else
      chk("cdb_clear", bus.clear_en, 0);
`endif
      bus.cdb_valid = 1'b0;
      bus.entry_valid = 0;
      #1;
      tick(); tick();
      // asynchronous reset drops the output immediately
      alloc(2, 1, 1, 7'h22);
      @(negedge clk);
      tick(); @(negedge clk);
      chk("ar_pre_valid", bus.issue_valid, 1);
      bus.entry_valid[3] = 1'b1;
      bus.entry_rs1_ready[3] = 1'b1;
      bus.entry_rs2_ready[3] = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", bus.issue_valid, 0);
      chk("ar_idx", bus.issue_idx, 0);
      chk("ar_instr", bus.issue_instr, 0);
      chk("ar_clear", bus.clear_en, 0);
      @(posedge clk); #1;
      chk("ar_hold_valid", bus.issue_valid, 0);
      chk("ar_hold_clear", bus.clear_en, 0);
      bus.entry_valid = 0;
      rst_n = 1'b1;
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
